// File: rtl/wdt_pkg.sv
// Shared types and defaults for the watchdog bite handler.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IRQ   = 2'b01,
    ST_RESET = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_ZERO_GRACE  = 2'b01,
    CAUSE_EXPIRED     = 2'b10,
    CAUSE_SECOND_BITE = 2'b11
  } cause_t;

  localparam int unsigned GRACE_W_DEF  = 16;
  localparam int unsigned RST_HOLD_DEF = 16;

  // Width needed to hold the value RST_HOLD itself.
  function automatic int unsigned hold_width(input int unsigned hold);
    return (hold < 2) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/wdt_down_counter.sv
// Loadable down counter that saturates at zero; last is high when count == 1.
module wdt_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/wdt_bite_handler.sv
// Watchdog bite escalation: first bite raises irq and opens a grace window,
// ack clears the watchdog, expiry or a second bite requests a timed system
// reset and records a sticky cause code.
// Optional build macro WDT_BITE_LOG_EN adds bite_cnt_o and last_grace_o.
module wdt_bite_handler
  import wdt_pkg::*;
#(
  parameter int unsigned GRACE_W  = GRACE_W_DEF,
  parameter int unsigned RST_HOLD = RST_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bite_i,
  input  logic [GRACE_W-1:0] grace_i,
  input  logic               irq_ack_i,
  input  logic               cause_clr_i,
  output logic               irq_o,
  output logic               wdt_clr_o,
  output logic               sys_rst_req_o,
  output logic [1:0]         cause_o,
`ifdef WDT_BITE_LOG_EN
  output logic [7:0]         bite_cnt_o,
  output logic [GRACE_W-1:0] last_grace_o,
`endif
  output logic               busy_o
);

  localparam int unsigned HOLD_W = hold_width(RST_HOLD);

  state_t state, state_nxt;
  cause_t new_cause;

  logic bite_idle, enter_irq, irq_bite, irq_ack, irq_exp;
  logic enter_reset, hold_done, g_dec, h_dec;
  logic g_last, h_last;

  // Grace window counter: loaded on the accepted first bite.
  wdt_down_counter #(.W(GRACE_W)) u_grace_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (enter_irq),
    .load_val (grace_i),
    .dec      (g_dec),
    .last     (g_last)
  );

  // Reset-hold counter: loaded on every entry into the reset request.
  wdt_down_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (enter_reset),
    .load_val (HOLD_W'(RST_HOLD)),
    .dec      (h_dec),
    .last     (h_last)
  );

  // Event decode with IRQ priority: bite, then ack, then window expiry.
  always_comb begin
    bite_idle   = (state == ST_IDLE) && bite_i;
    enter_irq   = bite_idle && (grace_i != '0);
    irq_bite    = (state == ST_IRQ) && bite_i;
    irq_ack     = (state == ST_IRQ) && !bite_i && irq_ack_i;
    irq_exp     = (state == ST_IRQ) && !bite_i && !irq_ack_i && g_last;
    g_dec       = (state == ST_IRQ) && !bite_i && !irq_ack_i && !g_last;
    enter_reset = (bite_idle && (grace_i == '0)) || irq_bite || irq_exp;
    hold_done   = (state == ST_RESET) && h_last;
    h_dec       = (state == ST_RESET);
    new_cause   = CAUSE_NONE;
    if (bite_idle)     new_cause = CAUSE_ZERO_GRACE;
    else if (irq_bite) new_cause = CAUSE_SECOND_BITE;
    else if (irq_exp)  new_cause = CAUSE_EXPIRED;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    if (enter_reset)                  state_nxt = ST_RESET;
    else if (enter_irq)               state_nxt = ST_IRQ;
    else if (irq_ack || hold_done)    state_nxt = ST_IDLE;
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      irq_o         <= 1'b0;
      wdt_clr_o     <= 1'b0;
      sys_rst_req_o <= 1'b0;
      busy_o        <= 1'b0;
      cause_o       <= CAUSE_NONE;
    end else begin
      state         <= state_nxt;
      irq_o         <= (state_nxt == ST_IRQ);
      sys_rst_req_o <= (state_nxt == ST_RESET);
      busy_o        <= (state_nxt != ST_IDLE);
      wdt_clr_o     <= irq_ack || hold_done;
      // A cause write beats a same-cycle clear.
      if (enter_reset) begin
        cause_o <= new_cause;
      end else if ((state == ST_IDLE) && cause_clr_i) begin
        cause_o <= CAUSE_NONE;
      end
    end
  end

`ifdef WDT_BITE_LOG_EN
  // Escalation log: saturating reset-entry count and last accepted grace.
  always_ff @(posedge clk) begin
    if (rst) begin
      bite_cnt_o   <= '0;
      last_grace_o <= '0;
    end else begin
      if (enter_reset && (bite_cnt_o != 8'hFF)) begin
        bite_cnt_o <= bite_cnt_o + 8'd1;
      end
      if (bite_idle) begin
        last_grace_o <= grace_i;
      end
    end
  end
`endif

endmodule

// File: doc/wdt_bite_handler.md
Name: wdt_bite_handler

Overview:
Sits on the timeout side of the watchdog timer and implements the escalation policy for its one-cycle timeout ("bite") pulse.
- First bite raises an interrupt to the RISC-V core and opens a grace window.
- A software acknowledge inside the window clears the watchdog.
- Window expiry or a second bite escalates to a fixed-length system reset request.
- A sticky cause code records why the reset happened, for boot firmware.

Parameters:
GRACE_W, 16, width of grace-period count (cycles)
RST_HOLD, 16, cycles sys_rst_req_o is held high (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
bite_i  in  1  timeout pulse from watchdog
grace_i  in  GRACE_W  grace window length in cycles; sampled only on bite acceptance
irq_ack_i  in  1  software acknowledge of watchdog interrupt
cause_clr_i  in  1  clears cause_o
irq_o  out  1  watchdog interrupt to core
wdt_clr_o  out  1  one-cycle pulse restarting watchdog counter
sys_rst_req_o  out  1  system reset request
cause_o  out  2  sticky cause: 00 none, 01 zero grace, 10 grace expired, 11 second bite
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Outputs are registered, decoded from state or registered flags. No combinational input-to-output path.
- States: IDLE, IRQ, RESET.
- IDLE:
  - bite_i with grace_i != 0: go to IRQ, load gcnt = grace_i.
  - bite_i with grace_i == 0: go to RESET, cause = 01.
  - Latency: bite at cycle N gives irq_o (or sys_rst_req_o) high at N+1.
- IRQ: irq_o = 1. Each cycle, with priority top to bottom:
  - bite_i: go to RESET, cause = 11. Bite beats ack on the same cycle.
  - irq_ack_i: go to IDLE; wdt_clr_o pulses high in the next cycle; irq_o low next cycle.
  - gcnt == 1: go to RESET, cause = 10. Ack on this same cycle beats expiry.
  - else gcnt decrements.
  - With grace G and no ack: irq_o is high for exactly G cycles (N+1..N+G); sys_rst_req_o rises at N+G+1.
- RESET:
  - sys_rst_req_o = 1 for exactly RST_HOLD cycles; hold counter is loaded on entry.
  - irq_o = 0. bite_i, irq_ack_i and cause_clr_i are ignored.
  - On the final hold cycle, go to IDLE; wdt_clr_o pulses in the first IDLE cycle.
- irq_ack_i in IDLE or RESET: no effect.
- cause_o:
  - Written on every RESET entry and holds across the reset request; only rst clears it implicitly.
  - cause_clr_i clears it only in IDLE. If clear and a new cause write occur in the same cycle, the write wins.
- rst mid-operation: returns to IDLE with all outputs 0 on the next edge, including mid-hold.
- Counters never wrap. gcnt is not decremented below 1; hold counter stops at 0.

Optional Feature:
WDT_BITE_LOG_EN
- Defined:
  - Adds output bite_cnt_o [7:0], a saturating count of RESET entries (stays at 255).
  - Adds output last_grace_o [GRACE_W-1:0], the latched grace_i of the most recent bite.
  - Both clear only on rst; cause_clr_i does not affect them.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package wdt_pkg:
  - State enum (IDLE/IRQ/RESET).
  - Cause codes: CAUSE_NONE, CAUSE_ZERO_GRACE, CAUSE_EXPIRED, CAUSE_SECOND_BITE.
  - Default widths.
- One natural sub-module: wdt_down_counter.
  - Loadable, saturating-at-zero down counter with a terminal flag.
  - Instantiated twice: grace counter and hold counter.

Test Plan:
- Ack path: grace_i=8, bite at cycle 10, ack at 14 -> irq_o high 11..14, wdt_clr_o at 15, sys_rst_req_o never high, cause_o=00.
- Expiry path: grace_i=8, RST_HOLD=16, bite at 10, no ack -> irq_o high 11..18; sys_rst_req_o high 19..34; cause_o=10; wdt_clr_o at 35.
- Second bite: grace_i=100, bite at 10, bite at 20 with ack at 20 -> RESET at 21, cause_o=11, no wdt_clr_o at 21.
- Zero grace / expiry tie: grace_i=0, bite -> sys_rst_req_o next cycle, irq_o never high, cause_o=01. Separately, grace_i=4 with ack on last window cycle -> IDLE, no reset.
- Cause handling: cause_clr_i during RESET -> cause_o unchanged; cause_clr_i in IDLE -> 00 next cycle. Clear coinciding with bite (grace_i=0) -> cause_o=01.
- Reset mid-hold: assert rst at hold cycle 5 -> next edge all outputs 0, state IDLE. With WDT_BITE_LOG_EN, 300 escalations -> bite_cnt_o=255.
